// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pid_pkg
//  Purpose  : Shared definitions for the speed PID controller: FSM state
//             encoding, default tuning constants, accumulator width and a
//             16-bit signed saturation helper.
//  Revision : 1.0  initial release
// ============================================================================
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERR  = 3'd1,
    S_MP   = 3'd2,
    S_MI   = 3'd3,
    S_MD   = 3'd4,
    S_SUM  = 3'd5,
    S_OUT  = 3'd6
  } state_t;

  localparam int FRAC_BITS_DEF = 8;
  localparam int U_MAX_DEF     = 1000;
  localparam int INT_LIM_DEF   = 800;
  localparam int ACC_W         = 34;

  // Clamp a 17-bit signed difference into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
    if (x > 17'sd32767)
      return 16'sh7FFF;
    else if (x < -17'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/speed_pid_if.sv
`default_nettype none
// ============================================================================
//  Module   : speed_pid_if
//  Purpose  : Bundle of the controller's sample input, gain/setpoint inputs
//             and command/status outputs.
//  Ports    : master drives en/setpoint/spdcnt/delta_valid/kp/ki/kd and
//             observes u_out/u_valid/u_sat/busy/ovr_cnt; slave is the
//             controller side.
//  Revision : 1.0  initial release
// ============================================================================
interface speed_pid_if;

  logic               en;
  logic signed [15:0] setpoint;
  logic signed [15:0] spdcnt;
  logic               delta_valid;
  logic signed [15:0] kp;
  logic signed [15:0] ki;
  logic signed [15:0] kd;
  logic signed [15:0] u_out;
  logic               u_valid;
  logic               u_sat;
  logic               busy;
  logic [7:0]         ovr_cnt;

  modport master (
    output en, setpoint, spdcnt, delta_valid, kp, ki, kd,
    input  u_out, u_valid, u_sat, busy, ovr_cnt
  );

  modport slave (
    input  en, setpoint, spdcnt, delta_valid, kp, ki, kd,
    output u_out, u_valid, u_sat, busy, ovr_cnt
  );

endinterface
`default_nettype wire

// File: rtl/sat_clamp.sv
`default_nettype none
// ============================================================================
//  Module   : sat_clamp
//  Purpose  : Signed saturating clamp from IN_W bits into [LOW, LIMIT],
//             narrowed to OUT_W bits, with a flag set when clamping occurred.
//  Ports    : din (IN_W signed), dout (OUT_W signed), clamped (1).
//  Revision : 1.0  initial release
// ============================================================================
module sat_clamp #(
  parameter int     IN_W  = 17,
  parameter int     OUT_W = 16,
  parameter longint LIMIT = 32767,
  parameter longint LOW   = -LIMIT
) (
  input  wire logic signed [IN_W-1:0]  din,
  output logic signed      [OUT_W-1:0] dout,
  output logic                         clamped
);

  localparam logic signed [IN_W-1:0] C_HI = IN_W'(LIMIT);
  localparam logic signed [IN_W-1:0] C_LO = IN_W'(LOW);

  always_comb begin
    dout    = din[OUT_W-1:0];
    clamped = 1'b0;
    if (din > C_HI) begin
      dout    = C_HI[OUT_W-1:0];
      clamped = 1'b1;
    end else if (din < C_LO) begin
      dout    = C_LO[OUT_W-1:0];
      clamped = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/speed_pid.sv
`default_nettype none
// ============================================================================
//  Module   : speed_pid
//  Purpose  : Discrete PID speed controller. Each accepted encoder sample is
//             processed by a 7-state sequence sharing one 16x16 multiplier,
//             producing a saturated signed command with conditional-
//             integration anti-windup.
//  Ports    : clk, rst_n (async, active-low), bus (speed_pid_if.slave).
//  Revision : 1.0  initial release
// ============================================================================
module speed_pid
  import pid_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int U_MAX     = U_MAX_DEF,
  parameter int INT_LIM   = INT_LIM_DEF
) (
  input wire logic   clk,
  input wire logic   rst_n,
  speed_pid_if.slave bus
);

  localparam longint INT_MAX_Q = longint'(INT_LIM) << FRAC_BITS;

  state_t state, state_nx;

  // Shadow copies taken at capture so mid-computation changes wait a sample
  logic signed [15:0] sp_s, meas_s, kp_s, ki_s, kd_s;
  logic signed [15:0] e_r, de_r, e_prev;
  logic               first;
  logic signed [31:0] prod, p_acc, integ;
  logic signed [ACC_W-1:0] t_r;
  logic [7:0]         ovr;

  logic capture;
  assign capture = bus.en && bus.delta_valid && (state == S_IDLE);

  // ---------------- error / derivative ----------------
  logic signed [16:0] e_diff;
  logic signed [15:0] e_val, de_val;
  logic               e_sat_unused;
  assign e_diff = {sp_s[15], sp_s} - {meas_s[15], meas_s};

  sat_clamp #(.IN_W(17), .OUT_W(16), .LIMIT(32767), .LOW(-32768)) u_e_clamp (
    .din(e_diff), .dout(e_val), .clamped(e_sat_unused)
  );

  assign de_val = first ? 16'sd0 : sat16({e_val[15], e_val} - {e_prev[15], e_prev});

  // ---------------- shared multiplier ----------------
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] mul_p;

  always_comb begin
    mul_a = kp_s;
    mul_b = e_r;
    case (state)
      S_MI:    mul_a = ki_s;
      S_MD:    begin mul_a = kd_s; mul_b = de_r; end
      default: ;
    endcase
  end

  assign mul_p = $signed({{16{mul_a[15]}}, mul_a}) * $signed({{16{mul_b[15]}}, mul_b});

  // ---------------- integrator ----------------
  logic signed [32:0] integ_sum;
  logic signed [31:0] integ_nx;
  logic               integ_sat_unused;
  logic               freeze;
  assign integ_sum = {integ[31], integ} + {prod[31], prod};

  sat_clamp #(.IN_W(33), .OUT_W(32), .LIMIT(INT_MAX_Q)) u_int_clamp (
    .din(integ_sum), .dout(integ_nx), .clamped(integ_sat_unused)
  );

  // Stop integrating while the output is pinned and the error pushes further
  assign freeze = bus.u_sat && (bus.u_out[15] == e_r[15]) && (e_r != 16'sd0);

  // ---------------- sum and output clamp ----------------
  logic signed [ACC_W-1:0] sum_s;
  logic signed [15:0]      u_nx;
  logic                    u_clamped;
  assign sum_s = {{(ACC_W-32){p_acc[31]}}, p_acc}
               + {{(ACC_W-32){integ[31]}}, integ}
               + {{(ACC_W-32){prod[31]}},  prod};

  sat_clamp #(.IN_W(ACC_W), .OUT_W(16), .LIMIT(U_MAX)) u_out_clamp (
    .din(t_r), .dout(u_nx), .clamped(u_clamped)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state <= S_IDLE;
    else if (!bus.en) state <= S_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.delta_valid) state_nx = S_ERR;
      S_ERR:   state_nx = S_MP;
      S_MP:    state_nx = S_MI;
      S_MI:    state_nx = S_MD;
      S_MD:    state_nx = S_SUM;
      S_SUM:   state_nx = S_OUT;
      S_OUT:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_s <= '0; meas_s <= '0; kp_s <= '0; ki_s <= '0; kd_s <= '0;
      e_r <= '0; de_r <= '0; e_prev <= '0; first <= 1'b1;
      prod <= '0; p_acc <= '0; integ <= '0; t_r <= '0;
      bus.u_out <= '0; bus.u_sat <= 1'b0; bus.u_valid <= 1'b0;
    end else if (!bus.en) begin
      integ <= '0; e_prev <= '0; first <= 1'b1;
      bus.u_out <= '0; bus.u_sat <= 1'b0; bus.u_valid <= 1'b0;
    end else begin
      bus.u_valid <= (state == S_OUT);
      case (state)
        S_IDLE: if (capture) begin
          sp_s <= bus.setpoint; meas_s <= bus.spdcnt;
          kp_s <= bus.kp; ki_s <= bus.ki; kd_s <= bus.kd;
        end
        S_ERR: begin
          e_r <= e_val; de_r <= de_val; e_prev <= e_val; first <= 1'b0;
        end
        S_MP: prod <= mul_p;
        S_MI: begin p_acc <= prod; prod <= mul_p; end
        S_MD: begin
          if (!freeze) integ <= integ_nx;
          prod <= mul_p;
        end
        S_SUM: t_r <= sum_s >>> FRAC_BITS;
        S_OUT: begin bus.u_out <= u_nx; bus.u_sat <= u_clamped; end
        default: ;
      endcase
    end
  end

  // ---------------- overrun counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovr <= '0;
    else if (bus.en && bus.delta_valid && (state != S_IDLE) && (ovr != 8'hFF))
      ovr <= ovr + 8'd1;
  end

  assign bus.ovr_cnt = ovr;
  assign bus.busy    = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_speed_pid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_speed_pid
//  Purpose  : Directed self-checking bench for speed_pid with hand-computed
//             expected command values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_speed_pid;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  speed_pid_if bus ();

  speed_pid dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample for a single clock; returns at the negedge of the
  // first cycle after capture.
  task automatic strobe(input logic signed [15:0] sp, input logic signed [15:0] meas);
    @(negedge clk);
    bus.setpoint    = sp;
    bus.spdcnt      = meas;
    bus.delta_valid = 1'b1;
    @(negedge clk);
    bus.delta_valid = 1'b0;
  endtask

  // Wait (bounded) for u_valid; lat counts cycles since the sampling edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.u_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.u_valid) check("u_valid_timeout", 0, 1);
  endtask

  task automatic sample(input logic signed [15:0] sp, input logic signed [15:0] meas,
                        output int lat);
    strobe(sp, meas);
    wait_valid(lat);
  endtask

  task automatic clear_ctrl();
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    check("en0_u_out", bus.u_out, 0);
    check("en0_u_sat", bus.u_sat, 0);
    bus.en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nv;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.setpoint = '0; bus.spdcnt = '0; bus.delta_valid = 1'b0;
    bus.kp = '0; bus.ki = '0; bus.kd = '0;
    repeat (3) @(negedge clk);
    check("rst_u_out",   bus.u_out,   0);
    check("rst_u_valid", bus.u_valid, 0);
    check("rst_u_sat",   bus.u_sat,   0);
    check("rst_busy",    bus.busy,    0);
    check("rst_ovr",     bus.ovr_cnt, 0);
    rst_n = 1'b1;
    bus.en = 1'b1;

    // 1: proportional only, latency and busy window
    bus.kp = 16'sh0100;
    strobe(100, 40);
    check("t1_busy_c1", bus.busy, 1);
    wait_valid(lat);
    check("t1_latency", lat, 7);
    check("t1_u_out", bus.u_out, 60);
    check("t1_u_sat", bus.u_sat, 0);
    check("t1_busy_done", bus.busy, 0);
    @(negedge clk);
    check("t1_strobe_width", bus.u_valid, 0);
    check("t1_hold", bus.u_out, 60);

    // gains changed mid-computation apply only to the next sample
    strobe(50, 0);
    bus.kp = 16'sh0200; bus.setpoint = 999;
    wait_valid(lat);
    check("shadow_u_out", bus.u_out, 50);

    // floor on negative fractional result: 0x80 * -3 = -384 -> -2
    bus.kp = 16'sh0080;
    sample(0, 3, lat);
    check("floor_u_out", bus.u_out, -2);

    // negative saturation
    bus.kp = 16'sh7FFF;
    sample(0, 2000, lat);
    check("negsat_u_out", bus.u_out, -1000);
    check("negsat_u_sat", bus.u_sat, 1);

    // 2: integral only
    clear_ctrl();
    bus.kp = 0; bus.ki = 16'sh0080; bus.kd = 0;
    sample(10, 0, lat); check("t2_s1", bus.u_out, 5);
    sample(10, 0, lat); check("t2_s2", bus.u_out, 10);
    sample(10, 0, lat); check("t2_s3", bus.u_out, 15);

    // 3: integrator clamp, then output saturation with the integrator held
    sample(2000, 0, lat); check("t3_clamp1", bus.u_out, 800);
    check("t3_clamp1_sat", bus.u_sat, 0);
    sample(2000, 0, lat); check("t3_clamp2", bus.u_out, 800);
    bus.kp = 16'sh7FFF;
    sample(2000, 0, lat);
    check("t3_sat_u_out", bus.u_out, 1000);
    check("t3_sat_flag", bus.u_sat, 1);
    bus.kp = 0;
    sample(2000, 0, lat); check("t3_after_sat", bus.u_out, 800);

    // anti-windup below the integrator limit
    clear_ctrl();
    bus.kp = 16'sh7FFF; bus.ki = 16'sh0080;
    sample(10, 0, lat); check("aw_s1", bus.u_out, 1000);
    sample(10, 0, lat); check("aw_s2", bus.u_out, 1000);
    bus.kp = 0;
    sample(10, 0, lat); check("aw_frozen", bus.u_out, 5);
    check("aw_frozen_sat", bus.u_sat, 0);
    sample(10, 0, lat); check("aw_resume", bus.u_out, 10);

    // 4: derivative only, first sample has de=0
    clear_ctrl();
    bus.kp = 0; bus.ki = 0; bus.kd = 16'sh0100;
    sample(0, 0, lat);  check("t4_first", bus.u_out, 0);
    sample(0, 20, lat); check("t4_second", bus.u_out, -20);

    // 5: overrun
    strobe(0, 0);
    @(negedge clk);
    strobe(0, 0);
    nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.u_valid) nv++;
    end
    check("t5_one_valid", nv, 1);
    check("t5_ovr1", bus.ovr_cnt, 1);
    @(negedge clk);
    bus.delta_valid = 1'b1;
    repeat (400) @(negedge clk);
    bus.delta_valid = 1'b0;
    check("t5_ovr_sat", bus.ovr_cnt, 255);
    repeat (10) @(negedge clk);

    // 6: asynchronous reset during MI
    bus.kp = 16'sh0100; bus.ki = 0; bus.kd = 0;
    sample(30, 0, lat); check("t6_pre", bus.u_out, 30);
    strobe(50, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_u_out", bus.u_out, 0);
    check("t6_rst_busy",  bus.busy,  0);
    check("t6_rst_ovr",   bus.ovr_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.u_valid) nv++;
    end
    check("t6_no_valid", nv, 0);

    // en toggle restarts integrator and derivative history
    bus.kp = 0; bus.ki = 16'sh0080; bus.kd = 16'sh0100;
    sample(0, -10, lat); check("t6_pre_en", bus.u_out, 5);
    clear_ctrl();
    sample(0, -20, lat); check("t6_post_en", bus.u_out, 10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
